dmem_noc_req_ctrl: RTL and testbench

- Protocol bridge between the SCR1 LSU data-memory port and the NoC packet path of a core router.
- Converts each LSU request into one request packet for the splitter: destination node, packet id and payload.
- Matches the response packet delivered by the packet collector and returns RDY/ER plus read data to the LSU.
- At most one transaction is outstanding; a watchdog converts lost responses into bus errors.

---
 rtl/dmem_noc_req_ctrl_pkg.sv | 21 ++
 rtl/dmem_noc_req_ctrl.sv | 167 ++++++++++++++++
 tb/tb_dmem_noc_req_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_noc_req_ctrl_pkg.sv
// rtl/dmem_noc_req_ctrl_pkg.sv - SCR1 data-memory interface types used by the NoC request bridge
package dmem_noc_req_ctrl_pkg;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

endpackage

// File: rtl/dmem_noc_req_ctrl.sv
// rtl/dmem_noc_req_ctrl.sv - LSU dmem port to NoC request/response bridge (optional DMEM_NOC_POSTED_WRITE_EN)
module dmem_noc_req_ctrl
    import dmem_noc_req_ctrl_pkg::*;
#(
    parameter int NODE_ID         = 0,
    parameter int NODE_COUNT      = 9,
    parameter int PACKET_ID_WIDTH = 5,
    parameter int NODE_SEL_LSB    = 28,
    parameter int TIMEOUT_CYCLES  = 1024,
    localparam int NW             = $clog2(NODE_COUNT)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       lsu2dmem_req_i,
    input  type_scr1_mem_cmd_e         lsu2dmem_cmd_i,
    input  type_scr1_mem_width_e       lsu2dmem_width_i,
    input  logic [31:0]                lsu2dmem_addr_i,
    input  logic [31:0]                lsu2dmem_wdata_i,
    output logic                       dmem2lsu_req_ack_o,
    output logic [31:0]                dmem2lsu_rdata_o,
    output type_scr1_mem_resp_e        dmem2lsu_resp_o,
    output logic [66:0]                pkt_out_o,
    output logic [NW-1:0]              node_dest_o,
    output logic [PACKET_ID_WIDTH-1:0] packet_id_o,
    output logic                       pkt_valid_o,
    input  logic                       pkt_ready_i,
    input  logic                       rsp_valid_i,
    input  logic [32:0]                rsp_data_i,
    input  logic [NW-1:0]              rsp_node_i,
    input  logic [PACKET_ID_WIDTH-1:0] rsp_packet_id_i,
    output logic                       rsp_ready_o
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [7:0] LP_REQ_ID = 8'(NODE_ID);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT, ST_RESP} state_e;

    state_e                     r_state;
    state_e                     w_next;
    type_scr1_mem_cmd_e         r_cmd;
    type_scr1_mem_width_e       r_width;
    logic [31:0]                r_addr;
    logic [31:0]                r_wdata;
    logic [NW-1:0]              r_dest;
    logic [PACKET_ID_WIDTH-1:0] r_pkt_id;
    logic [PACKET_ID_WIDTH-1:0] r_issued_id;
    logic [TW-1:0]              r_timer;
    logic [7:0]                 r_stale_cnt;
    logic [31:0]                r_rdata;
    logic                       r_err;

    logic [NW-1:0] w_req_dest;
    logic          w_bad_node;
    logic          w_match;
    logic          w_stale;
    logic          w_expire;
    logic          w_posted;
    logic          w_unused;

    assign w_req_dest = lsu2dmem_addr_i[NODE_SEL_LSB +: NW];
    assign w_bad_node = ({{(32-NW){1'b0}}, w_req_dest} >= 32'(NODE_COUNT));
    assign w_match    = (r_state == ST_WAIT) && rsp_valid_i &&
                        (rsp_packet_id_i == r_issued_id) && (rsp_node_i == r_dest);
    assign w_stale    = (r_state == ST_WAIT) && rsp_valid_i && !w_match;
    assign w_expire   = (TIMEOUT_CYCLES != 0) && (r_timer == TW'(TIMEOUT_CYCLES - 1));

`ifdef DMEM_NOC_POSTED_WRITE_EN
    assign w_posted = (r_cmd == SCR1_MEM_CMD_WR);
`else
    assign w_posted = 1'b0;
`endif

    // Requester id and the stale statistic are observation-only in this payload format
    assign w_unused = ^{LP_REQ_ID, r_stale_cnt};

    assign pkt_out_o   = {r_cmd, r_width, r_addr, r_wdata};
    assign node_dest_o = r_dest;
    assign packet_id_o = r_pkt_id;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next-state: bad node skips the NoC, posted writes skip WAIT, match beats expiry
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (lsu2dmem_req_i) w_next = w_bad_node ? ST_RESP : ST_SEND;
            ST_SEND: if (pkt_ready_i)    w_next = w_posted ? ST_RESP : ST_WAIT;
            ST_WAIT: if (w_match || w_expire) w_next = ST_RESP;
            default: w_next = ST_IDLE;
        endcase
    end

    // Outputs: LSU handshake, packet valid, response consume, one-cycle LSU response
    always_comb begin
        dmem2lsu_req_ack_o = 1'b0;
        pkt_valid_o        = 1'b0;
        rsp_ready_o        = 1'b0;
        dmem2lsu_resp_o    = SCR1_MEM_RESP_NOTRDY;
        dmem2lsu_rdata_o   = 32'h0;
        case (r_state)
            ST_IDLE: dmem2lsu_req_ack_o = lsu2dmem_req_i;
            ST_SEND: pkt_valid_o = 1'b1;
            ST_WAIT: rsp_ready_o = 1'b1;
            default: begin
                dmem2lsu_resp_o  = r_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
                dmem2lsu_rdata_o = (!r_err && r_cmd == SCR1_MEM_CMD_RD) ? r_rdata : 32'h0;
            end
        endcase
    end

    // Transaction datapath: request latch, id counter, watchdog, response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd       <= SCR1_MEM_CMD_RD;
            r_width     <= SCR1_MEM_WIDTH_BYTE;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_dest      <= '0;
            r_pkt_id    <= '0;
            r_issued_id <= '0;
            r_timer     <= '0;
            r_stale_cnt <= 8'h0;
            r_rdata     <= 32'h0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (lsu2dmem_req_i) begin
                        r_err   <= w_bad_node;
                        r_rdata <= 32'h0;
                        if (!w_bad_node) begin
                            r_cmd   <= lsu2dmem_cmd_i;
                            r_width <= lsu2dmem_width_i;
                            r_addr  <= lsu2dmem_addr_i;
                            r_wdata <= lsu2dmem_wdata_i;
                            r_dest  <= w_req_dest;
                        end
                    end
                end
                ST_SEND: begin
                    if (pkt_ready_i) begin
                        r_issued_id <= r_pkt_id;
                        r_pkt_id    <= r_pkt_id + 1'b1;
                        r_timer     <= '0;
                    end
                end
                ST_WAIT: begin
                    r_timer <= r_timer + 1'b1;
                    if (w_match) begin
                        r_rdata <= rsp_data_i[31:0];
                        r_err   <= rsp_data_i[32];
                    end else if (w_expire) begin
                        r_err <= 1'b1;
                    end
                    if (w_stale && r_stale_cnt != 8'hFF) r_stale_cnt <= r_stale_cnt + 8'h1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_noc_req_ctrl.sv
// tb/tb_dmem_noc_req_ctrl.sv - vector table plus directed sequences for dmem_noc_req_ctrl
module tb_dmem_noc_req_ctrl;
    import dmem_noc_req_ctrl_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 req;
    type_scr1_mem_cmd_e   cmd;
    type_scr1_mem_width_e width;
    logic [31:0]          addr, wdata;
    logic                 ack;
    logic [31:0]          rdata;
    type_scr1_mem_resp_e  resp;
    logic [66:0]          pkt;
    logic [3:0]           dest;
    logic [4:0]           pid;
    logic                 pv, pr, rv, rr;
    logic [32:0]          rd;
    logic [3:0]           rn;
    logic [4:0]           rid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_noc_req_ctrl #(
        .NODE_ID(0), .NODE_COUNT(9), .PACKET_ID_WIDTH(5),
        .NODE_SEL_LSB(28), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .lsu2dmem_req_i(req), .lsu2dmem_cmd_i(cmd), .lsu2dmem_width_i(width),
        .lsu2dmem_addr_i(addr), .lsu2dmem_wdata_i(wdata),
        .dmem2lsu_req_ack_o(ack), .dmem2lsu_rdata_o(rdata), .dmem2lsu_resp_o(resp),
        .pkt_out_o(pkt), .node_dest_o(dest), .packet_id_o(pid), .pkt_valid_o(pv),
        .pkt_ready_i(pr), .rsp_valid_i(rv), .rsp_data_i(rd), .rsp_node_i(rn),
        .rsp_packet_id_i(rid), .rsp_ready_o(rr)
    );

    typedef struct {
        logic        req;
        logic        wr;
        logic [31:0] addr;
        logic        pr;
        logic        rv;
        logic [32:0] rd;
        logic [3:0]  rn;
        logic [4:0]  rid;
        logic        e_ack;
        logic        e_pv;
        logic [3:0]  e_dest;
        logic [4:0]  e_pid;
        logic        e_rr;
        logic [1:0]  e_resp;
        logic [31:0] e_rdata;
        logic [66:0] e_pkt;
    } vec_t;

    localparam logic [1:0] R_IDLE = 2'b00;
    localparam logic [1:0] R_OK   = 2'b01;
    localparam logic [1:0] R_ER   = 2'b10;

    vec_t vt[14];

    function automatic vec_t mk(logic q, logic w, logic [31:0] a, logic p, logic v,
                                logic [32:0] d, logic [3:0] n, logic [4:0] i,
                                logic eack, logic epv, logic [3:0] edst, logic [4:0] epid,
                                logic err_, logic [1:0] ersp, logic [31:0] erd, logic [66:0] epk);
        vec_t r;
        r.req = q; r.wr = w; r.addr = a; r.pr = p; r.rv = v; r.rd = d; r.rn = n; r.rid = i;
        r.e_ack = eack; r.e_pv = epv; r.e_dest = edst; r.e_pid = epid; r.e_rr = err_;
        r.e_resp = ersp; r.e_rdata = erd; r.e_pkt = epk;
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        req = 1'b0; cmd = SCR1_MEM_CMD_RD; width = SCR1_MEM_WIDTH_WORD;
        addr = 32'h0; wdata = 32'h0; pr = 1'b0; rv = 1'b0; rd = 33'h0; rn = 4'h0; rid = 5'h0;
    endtask

    task automatic apply_reset(input string name);
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        @(posedge clk);
        @(negedge clk);
        #1;
        check(name, {ack, pv, pkt, dest, pid, rr, 2'(resp), rdata}, 128'h0);
        rst = 1'b0;
    endtask

    // One READ with optional splitter backpressure and an immediate matching response
    task automatic do_read(input logic [31:0] a, input logic [4:0] eid, input logic [31:0] d,
                           input int hold, input string tag);
        logic [66:0] epk;
        epk = {1'b0, 2'b10, a, 32'h0};
        @(negedge clk);
        req = 1'b1; cmd = SCR1_MEM_CMD_RD; addr = a; wdata = 32'h0;
        #1 check({tag, "_ack"}, 128'(ack), 128'h1);
        @(negedge clk);
        req = 1'b0; addr = 32'hFFFF_FFFF; pr = 1'b0;
        for (int h = 0; h < hold; h++) begin
            #1 check({tag, "_bp"}, {pv, pkt, pid}, {1'b1, epk, eid});
            @(negedge clk);
        end
        pr = 1'b1;
        #1 check({tag, "_send"}, {pv, dest, pkt, pid}, {1'b1, a[31:28], epk, eid});
        @(negedge clk);
        pr = 1'b0; rv = 1'b1; rd = {1'b0, d}; rn = a[31:28]; rid = eid;
        #1 check({tag, "_wait"}, {rr, 2'(resp)}, {1'b1, R_IDLE});
        @(negedge clk);
        rv = 1'b0;
        #1 check({tag, "_resp"}, {rr, 2'(resp), rdata}, {1'b0, R_OK, d});
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        apply_reset("reset_state");

        //            req wr addr          pr rv rd                  rn    rid    ack pv dest  pid    rr resp    rdata          pkt
        vt[0]  = mk(1, 0, 32'h2000_0010, 0, 0, 33'h0,              4'd0, 5'd0, 1, 0, 4'd0, 5'd0, 0, R_IDLE, 32'h0,         67'h0);
        vt[1]  = mk(0, 0, 32'h0,         1, 0, 33'h0,              4'd0, 5'd0, 0, 1, 4'd2, 5'd0, 0, R_IDLE, 32'h0,         {3'b010, 32'h2000_0010, 32'h0});
        vt[2]  = mk(0, 0, 32'h0,         0, 0, 33'h0,              4'd0, 5'd0, 0, 0, 4'd0, 5'd1, 1, R_IDLE, 32'h0,         67'h0);
        vt[3]  = mk(0, 0, 32'h0,         0, 1, {1'b0,32'hDEADBEEF},4'd2, 5'd0, 0, 0, 4'd0, 5'd1, 1, R_IDLE, 32'h0,         67'h0);
        vt[4]  = mk(0, 0, 32'h0,         0, 0, 33'h0,              4'd0, 5'd0, 0, 0, 4'd0, 5'd1, 0, R_OK,   32'hDEADBEEF,  67'h0);
        vt[5]  = mk(1, 0, 32'hF000_0000, 0, 0, 33'h0,              4'd0, 5'd0, 1, 0, 4'd0, 5'd1, 0, R_IDLE, 32'h0,         67'h0);
        vt[6]  = mk(0, 0, 32'h0,         0, 0, 33'h0,              4'd0, 5'd0, 0, 0, 4'd0, 5'd1, 0, R_ER,   32'h0,         67'h0);
        vt[7]  = mk(1, 0, 32'h2000_0020, 0, 0, 33'h0,              4'd0, 5'd0, 1, 0, 4'd0, 5'd1, 0, R_IDLE, 32'h0,         67'h0);
        vt[8]  = mk(0, 0, 32'h0,         1, 0, 33'h0,              4'd0, 5'd0, 0, 1, 4'd2, 5'd1, 0, R_IDLE, 32'h0,         {3'b010, 32'h2000_0020, 32'h0});
        vt[9]  = mk(0, 0, 32'h0,         0, 1, {1'b0,32'h11111111},4'd2, 5'd3, 0, 0, 4'd0, 5'd2, 1, R_IDLE, 32'h0,         67'h0);
        vt[10] = mk(0, 0, 32'h0,         0, 1, {1'b0,32'h22222222},4'd5, 5'd1, 0, 0, 4'd0, 5'd2, 1, R_IDLE, 32'h0,         67'h0);
        vt[11] = mk(0, 0, 32'h0,         0, 1, {1'b0,32'hCAFEF00D},4'd2, 5'd1, 0, 0, 4'd0, 5'd2, 1, R_IDLE, 32'h0,         67'h0);
        vt[12] = mk(0, 0, 32'h0,         0, 0, 33'h0,              4'd0, 5'd0, 0, 0, 4'd0, 5'd2, 0, R_OK,   32'hCAFEF00D,  67'h0);
        vt[13] = mk(0, 0, 32'h0,         1, 1, {1'b0,32'h33333333},4'd2, 5'd1, 0, 0, 4'd0, 5'd2, 0, R_IDLE, 32'h0,         67'h0);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            req = vt[i].req; cmd = vt[i].wr ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
            width = SCR1_MEM_WIDTH_WORD; addr = vt[i].addr; wdata = 32'h0;
            pr = vt[i].pr; rv = vt[i].rv; rd = vt[i].rd; rn = vt[i].rn; rid = vt[i].rid;
            #1;
            check($sformatf("v%0d_ctl", i), {ack, pv, rr, pid}, {vt[i].e_ack, vt[i].e_pv, vt[i].e_rr, vt[i].e_pid});
            check($sformatf("v%0d_rsp", i), {2'(resp), rdata}, {vt[i].e_resp, vt[i].e_rdata});
            if (vt[i].e_pv) check($sformatf("v%0d_pkt", i), {dest, pkt}, {vt[i].e_dest, vt[i].e_pkt});
        end
        check("stale_cnt_table", 128'(dut.r_stale_cnt), 128'd2);

        // WRITE: posted build answers right after the handshake, otherwise waits for the ack
        @(negedge clk);
        drive_idle();
        req = 1'b1; cmd = SCR1_MEM_CMD_WR; addr = 32'h1000_0004; wdata = 32'h1234_5678;
        #1 check("wr_ack", 128'(ack), 128'h1);
        @(negedge clk);
        req = 1'b0; pr = 1'b1;
        #1 check("wr_send", {pv, dest, pid, pkt}, {1'b1, 4'd1, 5'd2, 1'b1, 2'b10, 32'h1000_0004, 32'h1234_5678});
        @(negedge clk);
        pr = 1'b0;
`ifdef DMEM_NOC_POSTED_WRITE_EN
        #1 check("wr_posted_rdy", {rr, 2'(resp), rdata}, {1'b0, R_OK, 32'h0});
`else
        rv = 1'b1; rd = {1'b1, 32'h0000_AAAA}; rn = 4'd1; rid = 5'd2;
        #1 check("wr_wait", {rr, 2'(resp)}, {1'b1, R_IDLE});
        @(negedge clk);
        rv = 1'b0;
        #1 check("wr_err_ack", {rr, 2'(resp), rdata}, {1'b0, R_ER, 32'h0});
`endif

        // Backpressure on the first transaction, ids wrap after 32
        apply_reset("reset_wrap");
        for (int k = 0; k < 33; k++) begin
            do_read({4'(k % 9), 28'(k * 16)}, 5'(k), 32'hA000_0000 + 32'(k),
                    (k == 0) ? 5 : 0, $sformatf("txn%0d", k));
        end
        @(negedge clk);
        #1 check("id_after_wrap", 128'(pid), 128'd1);

        // Watchdog: ER after exactly 16 WAIT cycles, late response later consumed as stale
        apply_reset("reset_timeout");
        @(negedge clk);
        req = 1'b1; cmd = SCR1_MEM_CMD_RD; addr = 32'h1000_0000;
        #1 check("to_ack", 128'(ack), 128'h1);
        @(negedge clk);
        req = 1'b0; pr = 1'b1;
        #1 check("to_send", {pv, pid}, {1'b1, 5'd0});
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            pr = 1'b0;
            #1 check($sformatf("to_wait%0d", c), {rr, 2'(resp)}, {1'b1, R_IDLE});
        end
        @(negedge clk);
        #1 check("to_er", {rr, 2'(resp), rdata}, {1'b0, R_ER, 32'h0});
        @(negedge clk);
        rv = 1'b1; rd = {1'b0, 32'h5555_5555}; rn = 4'd1; rid = 5'd0;
        #1 check("late_held_idle", 128'(rr), 128'h0);
        req = 1'b1; addr = 32'h1000_0000;
        #1 check("late_ack", 128'(ack), 128'h1);
        @(negedge clk);
        req = 1'b0; pr = 1'b1;
        #1 check("late_send", {pv, pid, rr}, {1'b1, 5'd1, 1'b0});
        @(negedge clk);
        pr = 1'b0;
        #1 check("late_stale", {rr, 2'(resp)}, {1'b1, R_IDLE});
        @(negedge clk);
        rd = {1'b0, 32'h0000_0077}; rid = 5'd1;
        #1 check("late_match", {rr, 2'(resp)}, {1'b1, R_IDLE});
        @(negedge clk);
        rv = 1'b0;
        #1 check("late_rdy", {2'(resp), rdata}, {R_OK, 32'h0000_0077});
        check("stale_cnt_late", 128'(dut.r_stale_cnt), 128'd1);

        // Reset while in WAIT abandons the transaction
        @(negedge clk);
        req = 1'b1; addr = 32'h3000_0000;
        @(negedge clk);
        req = 1'b0; pr = 1'b1;
        @(negedge clk);
        pr = 1'b0;
        #1 check("pre_rst_wait", 128'(rr), 128'h1);
        apply_reset("reset_in_wait");
        @(negedge clk);
        #1 check("post_rst_idle", {ack, pv, rr, 2'(resp)}, {1'b0, 1'b0, 1'b0, R_IDLE});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
